// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RV32/RV64 immediate generator with opcode auto-decode,
// illegal-opcode flag and a two-entry (main + skid) output buffer.
module imm_gen_pipe #(
    parameter int XLEN        = 32,
    parameter bit AUTO_DECODE = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_in,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction_in,
    input  logic [2:0]      imm_type_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm_out,
    output logic [2:0]      imm_type_out,
    output logic [31:0]     instruction_out,
    output logic            illegal_out
);
    localparam logic [2:0] T_NONE = 3'd0, T_I = 3'd1, T_S = 3'd2, T_B = 3'd3,
                           T_U = 3'd4, T_J = 3'd5, T_Z = 3'd6;
    localparam int W = XLEN + 36;

    logic [2:0]      dec_type, sel_type;
    logic            dec_ill, sel_ill;
    logic [31:0]     lo;
    logic [XLEN-1:0] imm;
    logic [W-1:0]    new_e, main_q, main_d, skid_q, skid_d;
    logic            main_v_q, main_v_d, skid_v_q, skid_v_d;
    logic            in_x, out_x;

    always_comb begin
        dec_type = T_NONE;
        dec_ill  = 1'b0;
        case (instruction_in[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: dec_type = T_I;
            7'b0100011:                         dec_type = T_S;
            7'b1100011:                         dec_type = T_B;
            7'b0110111, 7'b0010111:             dec_type = T_U;
            7'b1101111:                         dec_type = T_J;
            7'b1110011:                         dec_type = instruction_in[14] ? T_Z : T_NONE;
            7'b0110011, 7'b0001111:             dec_type = T_NONE;
            default:                            dec_ill  = 1'b1;
        endcase
    end

    assign sel_type = AUTO_DECODE ? dec_type : ((imm_type_in > T_Z) ? T_NONE : imm_type_in);
    assign sel_ill  = AUTO_DECODE && dec_ill;

    always_comb begin
        lo = (sel_type == T_I) ? {{20{instruction_in[31]}}, instruction_in[31:20]} :
             (sel_type == T_S) ? {{20{instruction_in[31]}}, instruction_in[31:25], instruction_in[11:7]} :
             (sel_type == T_B) ? {{20{instruction_in[31]}}, instruction_in[7], instruction_in[30:25],
                                  instruction_in[11:8], 1'b0} :
             (sel_type == T_U) ? {instruction_in[31:12], 12'b0} :
             (sel_type == T_J) ? {{12{instruction_in[31]}}, instruction_in[19:12], instruction_in[20],
                                  instruction_in[30:21], 1'b0} :
             (sel_type == T_Z) ? {27'b0, instruction_in[19:15]} : 32'b0;
    end

    // Bit 31 of lo is the sign for every format (Z has it cleared), so one widening covers RV64.
    assign imm   = XLEN'($signed(lo));
    assign new_e = {sel_ill, sel_type, instruction_in, imm};
    assign in_x  = in_valid && !skid_v_q;
    assign out_x = main_v_q && out_ready;

    always_comb begin
        main_d   = main_q;
        skid_d   = skid_q;
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        if (flush_in) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (skid_v_q) begin
            if (out_x) begin
                main_d   = skid_q;
                skid_v_d = 1'b0;
            end
        end else if (in_x) begin
            if (!main_v_q || out_x) begin
                main_d   = new_e;
                main_v_d = 1'b1;
            end else begin
                skid_d   = new_e;
                skid_v_d = 1'b1;
            end
        end else if (out_x) begin
            main_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q   <= '0;
            skid_q   <= '0;
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
        end else begin
            main_q   <= main_d;
            skid_q   <= skid_d;
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
        end
    end

    assign {illegal_out, imm_type_out, instruction_out, imm_out} = main_q;
    assign out_valid = main_v_q;
    assign in_ready  = !skid_v_q;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed checks of imm_gen_pipe formats, RV64 extension,
// manual type select, back-pressure, flush and asynchronous reset.
module tb_imm_gen_pipe;
    logic        clk = 1'b0;
    logic        rst_n, flush_in, in_valid, out_ready;
    logic [31:0] instruction_in;
    logic [2:0]  imm_type_in;

    logic        ir32, ov32, il32, ir64, ov64, il64, irm, ovm, ilm;
    logic [31:0] imm32, io32, io64, immm, iom;
    logic [63:0] imm64;
    logic [2:0]  ty32, ty64, tym;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1'b1)) u32 (
        .clk(clk), .rst_n(rst_n), .flush_in(flush_in), .in_valid(in_valid), .in_ready(ir32),
        .instruction_in(instruction_in), .imm_type_in(imm_type_in), .out_valid(ov32),
        .out_ready(out_ready), .imm_out(imm32), .imm_type_out(ty32),
        .instruction_out(io32), .illegal_out(il32));

    imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(1'b1)) u64 (
        .clk(clk), .rst_n(rst_n), .flush_in(flush_in), .in_valid(in_valid), .in_ready(ir64),
        .instruction_in(instruction_in), .imm_type_in(imm_type_in), .out_valid(ov64),
        .out_ready(out_ready), .imm_out(imm64), .imm_type_out(ty64),
        .instruction_out(io64), .illegal_out(il64));

    imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1'b0)) uman (
        .clk(clk), .rst_n(rst_n), .flush_in(flush_in), .in_valid(in_valid), .in_ready(irm),
        .instruction_in(instruction_in), .imm_type_in(imm_type_in), .out_valid(ovm),
        .out_ready(out_ready), .imm_out(immm), .imm_type_out(tym),
        .instruction_out(iom), .illegal_out(ilm));

    logic [31:0] t_inst [8] = '{32'hFFF00093, 32'hFE112E23, 32'h001000EF, 32'h300FD073,
                                32'h800002B7, 32'h123452B7, 32'hFE000EE3, 32'h0000007F};
    logic [31:0] t_e32  [8] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h00000800, 32'h0000001F,
                                32'h80000000, 32'h12345000, 32'hFFFFFFFC, 32'h00000000};
    logic [63:0] t_e64  [8] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'h800, 64'h1F,
                                64'hFFFFFFFF80000000, 64'h12345000, 64'hFFFFFFFFFFFFFFFC, 64'h0};
    logic [2:0]  t_ty   [8] = '{3'd1, 3'd2, 3'd5, 3'd6, 3'd4, 3'd4, 3'd3, 3'd0};
    logic        t_ill  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] bp_vec [4] = '{32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        vectors++;
        if ({ov32, ir32, imm32, ty32, io32, il32} !== {1'b0, 1'b1, 32'h0, 3'd0, 32'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset: ov=%b ir=%b imm=%h ty=%0d inst=%h ill=%b, want 0 1 0 0 0 0",
                     ov32, ir32, imm32, ty32, io32, il32);
        end
        vectors++;
        if ({ov64, ir64, imm64} !== {1'b0, 1'b1, 64'h0}) begin
            miscompares++;
            $display("FAIL reset64: ov=%b ir=%b imm=%h, want 0 1 0", ov64, ir64, imm64);
        end
    endtask

    task automatic test_formats;
        for (int i = 0; i < 8; i++) begin
            instruction_in = t_inst[i];
            imm_type_in    = t_ty[i];
            in_valid       = 1'b1;
            out_ready      = 1'b1;
            vectors++;
            if (ov32 !== 1'b0) begin
                miscompares++;
                $display("FAIL fmt%0d pre-valid: got %b want 0", i, ov32);
            end
            tick;
            in_valid = 1'b0;
            vectors++;
            if ({ov32, imm32, ty32, io32, il32} !== {1'b1, t_e32[i], t_ty[i], t_inst[i], t_ill[i]}) begin
                miscompares++;
                $display("FAIL fmt%0d rv32: ov=%b imm=%h ty=%0d inst=%h ill=%b, want 1 %h %0d %h %b",
                         i, ov32, imm32, ty32, io32, il32, t_e32[i], t_ty[i], t_inst[i], t_ill[i]);
            end
            vectors++;
            if ({ov64, imm64, ty64, il64} !== {1'b1, t_e64[i], t_ty[i], t_ill[i]}) begin
                miscompares++;
                $display("FAIL fmt%0d rv64: ov=%b imm=%h ty=%0d ill=%b, want 1 %h %0d %b",
                         i, ov64, imm64, ty64, il64, t_e64[i], t_ty[i], t_ill[i]);
            end
            vectors++;
            if ({ovm, immm, tym, ilm} !== {1'b1, t_e32[i], t_ty[i], 1'b0}) begin
                miscompares++;
                $display("FAIL fmt%0d manual: ov=%b imm=%h ty=%0d ill=%b, want 1 %h %0d 0",
                         i, ovm, immm, tym, ilm, t_e32[i], t_ty[i]);
            end
            tick;
            vectors++;
            if (ov32 !== 1'b0) begin
                miscompares++;
                $display("FAIL fmt%0d drain: ov=%b want 0", i, ov32);
            end
        end
    endtask

    task automatic test_manual_unlisted;
        instruction_in = 32'hFFF00093;
        imm_type_in    = 3'd7;
        in_valid       = 1'b1;
        out_ready      = 1'b1;
        tick;
        in_valid = 1'b0;
        vectors++;
        if ({ovm, immm, tym, ilm} !== {1'b1, 32'h0, 3'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL manual_unlisted: ov=%b imm=%h ty=%0d ill=%b, want 1 0 0 0", ovm, immm, tym, ilm);
        end
        tick;
    endtask

    task automatic test_back_pressure;
        int sent = 0, got = 0, occ = 0, cyc = 0;
        bit saw_drop = 0, in_x, out_x;
        while (got < 4 && cyc < 30) begin
            out_ready      = !(cyc >= 2 && cyc <= 5);
            in_valid       = (sent < 4);
            instruction_in = bp_vec[sent < 4 ? sent : 3];
            vectors++;
            if (ir32 !== (occ != 2)) begin
                miscompares++;
                $display("FAIL bp in_ready cyc%0d: got %b want %b", cyc, ir32, occ != 2);
            end
            vectors++;
            if (ov32 !== (occ != 0)) begin
                miscompares++;
                $display("FAIL bp out_valid cyc%0d: got %b want %b", cyc, ov32, occ != 0);
            end
            if (!ir32) saw_drop = 1;
            in_x  = in_valid && ir32;
            out_x = ov32 && out_ready;
            if (out_x) begin
                vectors++;
                if (io32 !== bp_vec[got]) begin
                    miscompares++;
                    $display("FAIL bp order item%0d: got %h want %h", got, io32, bp_vec[got]);
                end
                got++;
            end
            tick;
            occ  = occ + int'(in_x) - int'(out_x);
            sent = sent + int'(in_x);
            cyc++;
        end
        in_valid = 1'b0;
        vectors++;
        if (got != 4) begin
            miscompares++;
            $display("FAIL bp count: got %0d items want 4", got);
        end
        vectors++;
        if (!saw_drop) begin
            miscompares++;
            $display("FAIL bp stall: in_ready never dropped, got 1 want 0");
        end
        out_ready = 1'b1;
        tick;
    endtask

    task automatic fill_stall;
        out_ready      = 1'b0;
        in_valid       = 1'b1;
        instruction_in = 32'h00A00093;
        tick;
        instruction_in = 32'h00B00093;
        tick;
        vectors++;
        if ({ov32, ir32} !== 2'b10) begin
            miscompares++;
            $display("FAIL stall fill: ov=%b ir=%b want 1 0", ov32, ir32);
        end
    endtask

    task automatic test_flush;
        fill_stall;
        flush_in       = 1'b1;
        instruction_in = 32'h00C00093;
        tick;
        flush_in = 1'b0;
        in_valid = 1'b0;
        vectors++;
        if ({ov32, ir32} !== 2'b01) begin
            miscompares++;
            $display("FAIL flush: ov=%b ir=%b want 0 1", ov32, ir32);
        end
        in_valid       = 1'b1;
        out_ready      = 1'b1;
        instruction_in = 32'h00D00093;
        tick;
        in_valid = 1'b0;
        vectors++;
        if ({ov32, io32, imm32} !== {1'b1, 32'h00D00093, 32'h0000000D}) begin
            miscompares++;
            $display("FAIL flush next: ov=%b inst=%h imm=%h want 1 00d00093 0000000d", ov32, io32, imm32);
        end
        tick;
        vectors++;
        if (ov32 !== 1'b0) begin
            miscompares++;
            $display("FAIL flush drain: ov=%b want 0", ov32);
        end
    endtask

    task automatic test_async_reset;
        fill_stall;
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({ov32, ir32, imm32, ty32, io32, il32} !== {1'b1 ^ 1'b1, 1'b1, 32'h0, 3'd0, 32'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL async reset: ov=%b ir=%b imm=%h ty=%0d inst=%h ill=%b, want 0 1 0 0 0 0",
                     ov32, ir32, imm32, ty32, io32, il32);
        end
        tick;
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        tick;
        vectors++;
        if ({ov32, ir32} !== 2'b01) begin
            miscompares++;
            $display("FAIL post reset: ov=%b ir=%b want 0 1", ov32, ir32);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        flush_in       = 1'b0;
        in_valid       = 1'b0;
        out_ready      = 1'b1;
        instruction_in = 32'h0;
        imm_type_in    = 3'd0;
        #22 rst_n = 1'b1;
        tick;
        test_reset;
        test_formats;
        test_manual_unlisted;
        test_back_pressure;
        test_flush;
        test_async_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the SigmaCore decode stage. Takes a fetched instruction over a valid/ready handshake, selects the immediate format from the opcode (or from an externally supplied type), and sign/zero-extends it to XLEN bits. Results are registered with a two-entry skid buffer so decode back-pressure never drops an instruction. This is the next-generation immediate unit, adding RV64 support, CSR zimm, auto-decode, illegal-opcode flagging and flush.

## Interface
- XLEN, 32, datapath width; legal values 32 and 64.
- AUTO_DECODE, 1, 1 = derive type from opcode; 0 = use imm_type_in.
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush_in  input  1  synchronous pipeline flush.
- in_valid  input  1  instruction_in/imm_type_in valid.
- in_ready  output  1  block can accept this cycle.
- instruction_in  input  32  raw instruction.
- imm_type_in  input  3  sigma_pkg IMM_TYPE_*; used only when AUTO_DECODE=0.
- out_valid  output  1  output bundle valid.
- out_ready  input  1  consumer accepts this cycle.
- imm_out  output  XLEN  extended immediate.
- imm_type_out  output  3  type actually applied.
- instruction_out  output  32  instruction passthrough.
- illegal_out  output  1  opcode not recognised (AUTO_DECODE=1 only).

## Operation
- Types use the sigma_pkg encodings NONE, I, S, B, U, J, plus IMM_TYPE_Z, added to sigma_pkg as the next unused 3-bit code.
- Formats (low 32 bits, then sign-extend from bit 31 to XLEN): I = inst[31:20]; S = {inst[31:25], inst[11:7]}; B = {inst[31], inst[7], inst[30:25], inst[11:8], 0}; U = {inst[31:12], 12'b0}, sign-extended on RV64; J = {inst[31], inst[19:12], inst[20], inst[30:21], 0}; Z = zero-extended inst[19:15]; NONE = 0.
- Auto-decode on opcode inst[6:0]:
  - 0010011, 0000011, 1100111 -> I.
  - 0100011 -> S; 1100011 -> B.
  - 0110111, 0010111 -> U; 1101111 -> J.
  - 1110011 -> Z if funct3[2]=1, else NONE.
  - 0110011, 0001111 -> NONE.
  - Any other opcode -> NONE with illegal_out=1.
- AUTO_DECODE=0: imm_type_in is applied directly. Unlisted codes give NONE, imm 0, illegal_out=0.
- Storage is a main output register (drives outputs) plus one skid register.
  - Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
  - in_ready = !skid_valid, registered.
  - Transfer in with main empty, or main draining this cycle with skid empty: the computed result loads main.
  - Transfer in while main holds and is not draining: the result loads skid.
  - Main drains with skid full: skid moves to main and skid clears. The inbound item is blocked because in_ready=0.
- flush_in: clears out_valid and skid_valid at the next edge and discards any same-cycle input. in_ready=1 the cycle after.
- Output fields are stable while out_valid && !out_ready.

## Timing
- Reset (async assert, sync release):
  - out_valid=0, in_ready=1, imm_out=0, imm_type_out=NONE, instruction_out=0, illegal_out=0, skid empty.
- Latency: 1 cycle from the accepting edge to out_valid.
- Throughput: 1 per cycle with out_ready held high.
- Stall: out_ready low for 2+ cycles -> main and skid fill, in_ready falls the cycle after the skid loads.
- Release: first cycle out_ready=1 drains main, skid moves up, in_ready returns to 1 the next cycle.
- No combinational path from out_ready to in_ready.
- flush_in has priority over all transfers in the same cycle.
- rst_n asserted mid-stall discards both entries immediately.

## Test plan
- XLEN=32, ADDI 0xFFF00093 -> imm_out 0xFFFFFFFF, type I, out_valid one cycle after accept.
- SW 0xFE112E23 -> 0xFFFFFFFC (S).
- JAL 0x001000EF -> 0x00000800 (J).
- CSRRWI 0x300FD073 -> 0x0000001F (Z).
- XLEN=64: LUI 0x800002B7 -> 0xFFFFFFFF80000000; LUI 0x123452B7 -> 0x0000000012345000.
- Back-pressure: stream 4 instructions, out_ready=0 for cycles 2-5.
  - in_ready drops after 2 held entries.
  - Release yields all 4 in order, none duplicated or lost.
- Opcode 0x0000007F with AUTO_DECODE=1 -> illegal_out=1, imm 0, type NONE.
- flush_in during a full stall -> out_valid=0 next cycle, in_ready=1, next input emerges with latency 1.
- Reset pulse mid-stream -> all outputs take reset values asynchronously.
